mul_div_unit: RTL

Parametrised iterative multiply/divide unit attached to the Execute stage of the pipelined ARM core.
- Accepts one operation per Start pulse and runs a radix-2 shift-add (multiply) or restoring-subtract (divide) loop, one bit per cycle.
- Returns a double-width result: {Hi, Lo} product, or quotient/remainder.
- Raises Stall_Req so the hazard unit can hold Fetch/Decode and bubble Execute until the result is available.

---
 rtl/mul_div_unit_if.sv | 31 +++
 rtl/mul_div_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the Execute stage and the multiply/divide unit.
// Latency: none (wires only).
// Backpressure: none; the master watches stall_req and busy before issuing.
//   master : start, op, src_a, src_b, flush -> ; <- busy, done, stall_req, results, flags, div_zero
//   slave  : the unit side of the same signals
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;         // 00 UMUL, 01 SMUL, 10 UDIV, 11 SDIV
    logic [WIDTH-1:0] src_a;      // multiplicand / dividend
    logic [WIDTH-1:0] src_b;      // multiplier / divisor
    logic             flush;
    logic             busy;
    logic             done;
    logic             stall_req;
    logic [WIDTH-1:0] result_lo;  // product low word / quotient
    logic [WIDTH-1:0] result_hi;  // product high word / remainder
    logic [1:0]       flags;      // {N, Z}
    logic             div_zero;

    modport master (
        output start, op, src_a, src_b, flush,
        input  busy, done, stall_req, result_lo, result_hi, flags, div_zero
    );

    modport slave (
        input  start, op, src_a, src_b, flush,
        output busy, done, stall_req, result_lo, result_hi, flags, div_zero
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply (shift-add) / divide (restoring) unit, one bit per cycle.
// Latency: WIDTH cycles busy, done in cycle WIDTH+1 after start; divide-by-zero completes in 1 cycle.
// Backpressure: start is ignored while busy (no queueing); stall_req holds the pipeline meanwhile.
//   Ports: i_clk, i_reset (sync, active-high), io_bus (mul_div_unit_if.slave).
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    mul_div_unit_if.slave   io_bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_hi;        // partial product high word / partial remainder
    logic [WIDTH-1:0]   r_mq;        // multiplier shifting out / dividend shifting into quotient
    logic [WIDTH-1:0]   r_d;         // |multiplicand| or |divisor|
    logic               r_sign_q;
    logic               r_sign_r;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_res_lo;
    logic [WIDTH-1:0]   r_res_hi;
    logic [1:0]         r_flags;
    logic               r_div_zero;

    // Operand magnitudes; unsigned ops pass operands through untouched.
    logic [WIDTH-1:0]   w_abs_a, w_abs_b;
    logic               w_accept, w_b_zero, w_is_div;
    assign w_abs_a  = (io_bus.op[0] && io_bus.src_a[WIDTH-1]) ? -io_bus.src_a : io_bus.src_a;
    assign w_abs_b  = (io_bus.op[0] && io_bus.src_b[WIDTH-1]) ? -io_bus.src_b : io_bus.src_b;
    assign w_accept = io_bus.start && !io_bus.flush && (r_state != S_RUN);
    assign w_b_zero = (io_bus.src_b == '0);
    assign w_is_div = r_op[1];

    // Multiply step: conditionally add, then shift {carry, hi, mq} right by one.
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH-1:0]   w_mul_hi, w_mul_lo;
    assign w_mul_sum = {1'b0, r_hi} + (r_mq[0] ? {1'b0, r_d} : '0);
    assign w_mul_hi  = w_mul_sum[WIDTH:1];
    assign w_mul_lo  = {w_mul_sum[0], r_mq[WIDTH-1:1]};

    // Divide step: shift next dividend bit into the remainder, subtract if it fits.
    // The difference always fits WIDTH bits when it is taken, so modular subtraction suffices.
    logic [WIDTH:0]     w_div_shift;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_hi, w_div_lo;
    assign w_div_shift = {r_hi, r_mq[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_d});
    assign w_div_hi    = w_div_ge ? (w_div_shift[WIDTH-1:0] - r_d) : w_div_shift[WIDTH-1:0];
    assign w_div_lo    = {r_mq[WIDTH-2:0], w_div_ge};

    logic [WIDTH-1:0]   w_nx_hi, w_nx_lo;
    assign w_nx_hi = w_is_div ? w_div_hi : w_mul_hi;
    assign w_nx_lo = w_is_div ? w_div_lo : w_mul_lo;

    // Sign fix-up applied to the value the final iteration produces.
    logic [2*WIDTH-1:0] w_prod, w_prod_fx;
    logic [WIDTH-1:0]   w_quo_fx, w_rem_fx, w_fin_lo, w_fin_hi;
    logic [1:0]         w_fin_flags;
    assign w_prod      = {w_nx_hi, w_nx_lo};
    assign w_prod_fx   = (r_op == 2'b01 && r_sign_q) ? -w_prod : w_prod;
    assign w_quo_fx    = (r_op == 2'b11 && r_sign_q) ? -w_nx_lo : w_nx_lo;
    assign w_rem_fx    = (r_op == 2'b11 && r_sign_r) ? -w_nx_hi : w_nx_hi;
    assign w_fin_lo    = w_is_div ? w_quo_fx : w_prod_fx[WIDTH-1:0];
    assign w_fin_hi    = w_is_div ? w_rem_fx : w_prod_fx[2*WIDTH-1:WIDTH];
    assign w_fin_flags = w_is_div ? {w_fin_lo[WIDTH-1], (w_fin_lo == '0)}
                                  : {w_fin_hi[WIDTH-1], ({w_fin_hi, w_fin_lo} == '0)};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_hi       <= '0;
            r_mq       <= '0;
            r_d        <= '0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_res_lo   <= '0;
            r_res_hi   <= '0;
            r_flags    <= '0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    r_state <= S_IDLE;
                    if (w_accept) begin
                        r_op <= io_bus.op;
                        if (io_bus.op[1] && w_b_zero) begin
                            // Zero divisor completes immediately without iterating.
                            r_res_lo   <= '1;
                            r_res_hi   <= io_bus.src_a;
                            r_flags    <= 2'b10;
                            r_div_zero <= 1'b1;
                            r_done     <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_hi     <= '0;
                            r_mq     <= w_abs_a;
                            r_d      <= w_abs_b;
                            r_sign_q <= io_bus.op[0] & (io_bus.src_a[WIDTH-1] ^ io_bus.src_b[WIDTH-1]);
                            r_sign_r <= io_bus.op[0] & io_bus.src_a[WIDTH-1];
                            r_cnt    <= CNT_W'(WIDTH);
                            r_busy   <= 1'b1;
                            r_state  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (io_bus.flush) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_hi  <= w_nx_hi;
                        r_mq  <= w_nx_lo;
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_res_lo   <= w_fin_lo;
                            r_res_hi   <= w_fin_hi;
                            r_flags    <= w_fin_flags;
                            r_div_zero <= 1'b0;
                            r_done     <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= S_DONE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_bus.busy      = r_busy;
    assign io_bus.done      = r_done;
    assign io_bus.stall_req = (io_bus.start & ~r_busy) | r_busy;
    assign io_bus.result_lo = r_res_lo;
    assign io_bus.result_hi = r_res_hi;
    assign io_bus.flags     = r_flags;
    assign io_bus.div_zero  = r_div_zero;
endmodule
